dly_line_mch_bram: RTL

Multi-channel, time-multiplexed sample delay line on one read-first block RAM, with a runtime-programmable depth per channel. It is the generalised successor of the fixed two-port delay line and sits in the datapath wherever N interleaved channels each need their own N-sample delay, such as filter taps or correlator alignment. Outputs stay zero until a channel is primed, so reset and reconfiguration never leak stale RAM contents.

---
 rtl/dly_line_mch_bram_if.sv | 30 +++
 rtl/dly_line_mch_bram.sv | 118 +++++++++++
 2 files changed

// File: rtl/dly_line_mch_bram_if.sv
// Sample/config bus of the multi-channel delay line: the configuration port,
// the input sample stream and the delayed output stream.
interface dly_line_mch_bram_if #(
  parameter int WIDTH     = 32,
  parameter int NCH       = 4,
  parameter int MAX_DEPTH = 64
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int DW   = $clog2(MAX_DEPTH + 1);

  logic                    cfg_we;
  logic [CH_W-1:0]         cfg_ch;
  logic [DW-1:0]           cfg_depth;
  logic                    in_valid;
  logic [CH_W-1:0]         in_ch;
  logic signed [WIDTH-1:0] in_data;
  logic                    out_valid;
  logic [CH_W-1:0]         out_ch;
  logic signed [WIDTH-1:0] out_data;

  modport master (
    output cfg_we, cfg_ch, cfg_depth, in_valid, in_ch, in_data,
    input  out_valid, out_ch, out_data
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_depth, in_valid, in_ch, in_data,
    output out_valid, out_ch, out_data
  );
endinterface

// File: rtl/dly_line_mch_bram.sv
// Time-multiplexed per-channel delay line on one read-first RAM. Each channel has
// a programmable depth; outputs are masked to zero until the channel is primed.
module dly_line_mch_bram #(
  parameter int WIDTH     = 32,
  parameter int NCH       = 4,
  parameter int MAX_DEPTH = 64
) (
  input logic               clk,
  input logic               reset_n,
  dly_line_mch_bram_if.slave bus
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW   = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam int DW   = $clog2(MAX_DEPTH + 1);
  localparam int RW   = CH_W + AW;

  logic [WIDTH-1:0] r_mem [2**RW];
  logic [WIDTH-1:0] r_rd;

  logic [DW-1:0] r_depth [NCH];
  logic [AW-1:0] r_ptr   [NCH];
  logic [DW-1:0] r_fill  [NCH];
  logic [DW-1:0] w_depth_nx [NCH];
  logic [AW-1:0] w_ptr_nx   [NCH];
  logic [DW-1:0] w_fill_nx  [NCH];

  logic [DW-1:0]    w_cfg_depth;
  logic [DW-1:0]    w_dep;
  logic [AW-1:0]    w_ptr_cur;
  logic [DW-1:0]    w_fill_cur;
  logic             w_prime;
  logic [RW-1:0]    w_addr;

  logic             r_out_valid;
  logic [CH_W-1:0]  r_out_ch;
  logic             r_prime;
  logic             r_wr_en;
  logic [RW-1:0]    r_wr_addr;
  logic [WIDTH-1:0] r_wr_data;
  logic             r_fwd_hit;
  logic [WIDTH-1:0] r_fwd_data;

  always_comb begin
    w_cfg_depth = bus.cfg_depth;
    if (bus.cfg_depth == '0) begin
      w_cfg_depth = DW'(1);
    end else if (bus.cfg_depth > DW'(MAX_DEPTH)) begin
      w_cfg_depth = DW'(MAX_DEPTH);
    end
  end

  // Config is applied before the sample so a coincident sample sees the new depth.
  always_comb begin
    w_depth_nx = r_depth;
    w_ptr_nx   = r_ptr;
    w_fill_nx  = r_fill;
    if (bus.cfg_we) begin
      w_depth_nx[bus.cfg_ch] = w_cfg_depth;
      w_ptr_nx[bus.cfg_ch]   = '0;
      w_fill_nx[bus.cfg_ch]  = '0;
    end
    w_dep      = w_depth_nx[bus.in_ch];
    w_ptr_cur  = w_ptr_nx[bus.in_ch];
    w_fill_cur = w_fill_nx[bus.in_ch];
    w_prime    = (w_fill_cur == w_dep);
    w_addr     = {bus.in_ch, w_ptr_cur};
    if (bus.in_valid) begin
      w_ptr_nx[bus.in_ch]  = (DW'(w_ptr_cur) == w_dep - DW'(1)) ? '0 : w_ptr_cur + AW'(1);
      w_fill_nx[bus.in_ch] = w_prime ? w_fill_cur : w_fill_cur + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      r_rd           <= r_mem[w_addr];
      r_mem[w_addr]  <= bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) begin
        r_depth[i] <= DW'(MAX_DEPTH);
        r_ptr[i]   <= '0;
        r_fill[i]  <= '0;
      end
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_prime     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_fwd_hit   <= 1'b0;
      r_fwd_data  <= '0;
    end else begin
      r_depth     <= w_depth_nx;
      r_ptr       <= w_ptr_nx;
      r_fill      <= w_fill_nx;
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_out_ch <= bus.in_ch;
        r_prime  <= w_prime;
      end
      // Depth-1 back-to-back hits the word just written; take it from the write path.
      r_fwd_hit  <= bus.in_valid && r_wr_en && (r_wr_addr == w_addr);
      r_fwd_data <= r_wr_data;
      r_wr_en    <= bus.in_valid;
      if (bus.in_valid) begin
        r_wr_addr <= w_addr;
        r_wr_data <= bus.in_data;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_ch    = r_out_ch;
  assign bus.out_data  = !r_prime ? '0 : (r_fwd_hit ? r_fwd_data : r_rd);
endmodule
